panel_seq: RTL and testbench

PANEL_SEQ -- requirements
Module: panel_seq

---
 rtl/panel_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_panel_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_seq.sv
// panel_seq: front-panel sequencer for a small core.
//
// Decodes panel buttons into core control (reset, run, single/burst step),
// watches the core for stdin waits and halts, and performs panel-driven
// memory loads and looks through a single memory port.
//
// Ports
//   clk_i, rst_n                  clock, asynchronous active-low reset
//   btn_*_i                       single-cycle button pulses from the panel
//   btn_*_o                       button enables shown on the panel
//   led_ready_o/led_inwait_o/led_brk_o  panel LEDs
//   sw_addr_i, sw_data_i          panel switches
//   pc_i, cpu_done_i, cpu_halt_i, inwait_i, stdin_rdy_i  core/stdin status
//   core_rst_no                   synchronous active-low reset to the core
//   cpu_exec_o                    0 idle, 1 run, 2 step
//   pc_wen_o                      load core PC from sw_addr_i
//   mem_*                         panel memory port
//   disp_o                        data display register
//   dbg_state_o                   current FSM state, for observation
//
// Memory handshake: a request is presented while mem_val_o is high and is
// accepted in any cycle where mem_val_o and mem_rdy_i are both high; read
// data is returned on mem_rdata_i in the cycle after acceptance. Button
// driven requests last one cycle and are simply lost if not accepted; the
// settle-phase PC read holds mem_val_o high until it is accepted.

module panel_seq #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int SETTLE  = 3,
  parameter int BURST_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              btn_load_i,
  input  logic              btn_look_i,
  input  logic              btn_step_i,
  input  logic              btn_run_i,
  input  logic              btn_enter_i,
  input  logic              btn_stop_i,
  input  logic              btn_brk_i,
  output logic              btn_load_o,
  output logic              btn_look_o,
  output logic              btn_step_o,
  output logic              btn_run_o,
  output logic              btn_enter_o,
  output logic              btn_stop_o,
  output logic              btn_brk_o,
  output logic              led_ready_o,
  output logic              led_inwait_o,
  output logic              led_brk_o,
  input  logic [ADDR_W-1:0] sw_addr_i,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              cpu_done_i,
  input  logic              cpu_halt_i,
  input  logic              inwait_i,
  input  logic              stdin_rdy_i,
  output logic              core_rst_no,
  output logic [1:0]        cpu_exec_o,
  output logic              pc_wen_o,
  output logic              mem_val_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rdy_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] disp_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_READY    = 3'd0,
    S_STEP     = 3'd1,
    S_RUN      = 3'd2,
    S_PRE_WAIT = 3'd3,
    S_INWAIT   = 3'd4,
    S_POST     = 3'd5,
    S_PRE_HALT = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  localparam int                SET_W    = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0]  SETTLE_V = SET_W'(SETTLE);

  state_e              state_q;
  logic [BURST_W-1:0]  step_cnt_q;
  logic [SET_W-1:0]    settle_cnt_q;
  logic                done_prev_q;
  logic                bp_val_q;
  logic [ADDR_W-1:0]   bp_addr_q;
  logic                led_brk_q;
  logic [DATA_W-1:0]   disp_q;
  logic                rd_pend_q;   // an accepted read returns data this cycle

  logic                done_edge;
  logic                panel_state;
  logic                panel_req;
  logic                panel_acc;
  logic                pre_state;
  logic                pre_mem;
  logic                pre_acc;
  logic                bp_hit;
  logic [BURST_W-1:0]  burst_load;

  assign done_edge   = cpu_done_i & ~done_prev_q;
  assign panel_state = (state_q == S_READY) || (state_q == S_INWAIT) || (state_q == S_HALT);
  // Panel memory access only while the core is quiet (cpu_done_i high).
  assign panel_req   = panel_state && cpu_done_i && (btn_load_i || btn_look_i);
  assign panel_acc   = panel_req && mem_rdy_i;
  assign pre_state   = (state_q == S_PRE_WAIT) || (state_q == S_PRE_HALT);
  assign pre_mem     = pre_state && (settle_cnt_q == '0);
  assign pre_acc     = pre_mem && mem_rdy_i;
  assign bp_hit      = bp_val_q && (pc_i == bp_addr_q);
  // A burst count of zero on the switches still executes one instruction.
  assign burst_load  = (sw_data_i[BURST_W-1:0] == '0) ? BURST_W'(1) : sw_data_i[BURST_W-1:0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_READY;
      step_cnt_q   <= '0;
      settle_cnt_q <= '0;
      done_prev_q  <= 1'b0;
      bp_val_q     <= 1'b0;
      bp_addr_q    <= '0;
      led_brk_q    <= 1'b0;
      disp_q       <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      done_prev_q <= cpu_done_i;
      rd_pend_q   <= 1'b0;

      if (rd_pend_q) disp_q <= mem_rdata_i;

      // Load and look pressed together behave as a load.
      if (panel_acc) begin
        if (btn_load_i) disp_q    <= sw_data_i;
        else            rd_pend_q <= 1'b1;
      end

      if (pre_acc) rd_pend_q <= 1'b1;

      if (pre_state && (settle_cnt_q != '0)) settle_cnt_q <= settle_cnt_q - 1'b1;

      if (((state_q == S_READY) || (state_q == S_HALT)) && btn_brk_i) begin
        bp_val_q <= ~bp_val_q;
        if (!bp_val_q) bp_addr_q <= sw_addr_i;
      end

      case (state_q)
        S_READY: begin
          if (btn_run_i) begin
            state_q   <= S_RUN;
            led_brk_q <= 1'b0;
          end else if (btn_step_i) begin
            state_q    <= S_STEP;
            step_cnt_q <= burst_load;
            led_brk_q  <= 1'b0;
          end
        end
        S_STEP: begin
          if (inwait_i) begin
            state_q      <= S_PRE_WAIT;
            settle_cnt_q <= SETTLE_V;
          end else if (cpu_halt_i) begin
            state_q      <= S_PRE_HALT;
            settle_cnt_q <= SETTLE_V;
          end else if (done_edge) begin
            if (step_cnt_q == BURST_W'(1)) state_q    <= S_POST;
            else                           step_cnt_q <= step_cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (inwait_i) begin
            state_q      <= S_PRE_WAIT;
            settle_cnt_q <= SETTLE_V;
          end else if (cpu_halt_i) begin
            state_q      <= S_PRE_HALT;
            settle_cnt_q <= SETTLE_V;
          end else if (btn_stop_i) begin
            state_q <= S_POST;
          end else if (bp_hit) begin
            state_q   <= S_POST;
            led_brk_q <= 1'b1;
          end
        end
        S_POST: begin
          if (cpu_done_i) begin
            state_q <= S_READY;
          end else if (inwait_i) begin
            state_q      <= S_PRE_WAIT;
            settle_cnt_q <= SETTLE_V;
          end else if (cpu_halt_i) begin
            state_q      <= S_PRE_HALT;
            settle_cnt_q <= SETTLE_V;
          end
        end
        S_PRE_WAIT: if (pre_acc) state_q <= S_INWAIT;
        S_PRE_HALT: if (pre_acc) state_q <= S_HALT;
        S_INWAIT:   if (btn_enter_i) state_q <= S_READY;
        S_HALT:     if (btn_load_i || btn_look_i) state_q <= S_READY;
        default:    state_q <= S_READY;
      endcase
    end
  end

  always_comb begin
    btn_load_o   = 1'b0;
    btn_look_o   = 1'b0;
    btn_step_o   = 1'b0;
    btn_run_o    = 1'b0;
    btn_enter_o  = 1'b0;
    btn_stop_o   = 1'b0;
    btn_brk_o    = 1'b0;
    led_ready_o  = 1'b0;
    led_inwait_o = 1'b0;
    core_rst_no  = 1'b0;
    cpu_exec_o   = 2'd0;
    pc_wen_o     = 1'b0;
    mem_val_o    = 1'b0;
    mem_wen_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    case (state_q)
      S_READY: begin
        btn_load_o  = 1'b1;
        btn_look_o  = 1'b1;
        btn_step_o  = 1'b1;
        btn_run_o   = 1'b1;
        btn_brk_o   = 1'b1;
        btn_enter_o = stdin_rdy_i;
        led_ready_o = 1'b1;
      end
      S_STEP: begin
        core_rst_no = 1'b1;
        cpu_exec_o  = 2'd2;
      end
      S_RUN: begin
        core_rst_no = 1'b1;
        cpu_exec_o  = 2'd1;
        btn_stop_o  = 1'b1;
      end
      S_POST: begin
        core_rst_no = 1'b1;
      end
      S_PRE_WAIT, S_PRE_HALT: begin
        // The core stays out of reset only in the first settle cycle;
        // afterwards it is held quiet while the panel reads memory at pc_i.
        core_rst_no = (settle_cnt_q == SETTLE_V);
        if (pre_mem) begin
          mem_val_o  = 1'b1;
          mem_addr_o = pc_i;
        end
      end
      S_INWAIT: begin
        btn_load_o   = 1'b1;
        btn_look_o   = 1'b1;
        btn_enter_o  = 1'b1;
        led_inwait_o = 1'b1;
      end
      S_HALT: begin
        btn_load_o  = 1'b1;
        btn_look_o  = 1'b1;
        btn_brk_o   = 1'b1;
        btn_enter_o = stdin_rdy_i;
        led_ready_o = 1'b1;
      end
      default: ;
    endcase

    if (panel_req) begin
      mem_val_o   = 1'b1;
      mem_wen_o   = btn_load_i;
      mem_addr_o  = sw_addr_i;
      mem_wdata_o = sw_data_i;
      pc_wen_o    = 1'b1;
    end
  end

  assign led_brk_o   = led_brk_q;
  assign disp_o      = disp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_panel_seq.sv
// Testbench for panel_seq: randomized scenarios checked against a simple
// memory/behaviour model held in the bench.

module tb_panel_seq;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ST = 3;
  localparam int BW = 4;

  localparam logic [2:0] ST_READY    = 3'd0;
  localparam logic [2:0] ST_STEP     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_PRE_WAIT = 3'd3;
  localparam logic [2:0] ST_INWAIT   = 3'd4;
  localparam logic [2:0] ST_POST     = 3'd5;
  localparam logic [2:0] ST_PRE_HALT = 3'd6;
  localparam logic [2:0] ST_HALT     = 3'd7;

  logic          clk_i, rst_n;
  logic          btn_load_i, btn_look_i, btn_step_i, btn_run_i, btn_enter_i, btn_stop_i, btn_brk_i;
  logic          btn_load_o, btn_look_o, btn_step_o, btn_run_o, btn_enter_o, btn_stop_o, btn_brk_o;
  logic          led_ready_o, led_inwait_o, led_brk_o;
  logic [AW-1:0] sw_addr_i, pc_i, mem_addr_o;
  logic [DW-1:0] sw_data_i, mem_wdata_o, mem_rdata_i, disp_o;
  logic          cpu_done_i, cpu_halt_i, inwait_i, stdin_rdy_i;
  logic          core_rst_no, pc_wen_o, mem_val_o, mem_wen_o, mem_rdy_i;
  logic [1:0]    cpu_exec_o;
  logic [2:0]    dbg_state_o;

  logic [DW-1:0] mem     [256];  // memory behind the port
  logic [DW-1:0] ref_mem [256];  // expected memory contents
  logic [DW-1:0] exp_disp;
  int            checks, errors;

  panel_seq #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(ST), .BURST_W(BW)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .btn_load_i(btn_load_i), .btn_look_i(btn_look_i), .btn_step_i(btn_step_i),
    .btn_run_i(btn_run_i), .btn_enter_i(btn_enter_i), .btn_stop_i(btn_stop_i),
    .btn_brk_i(btn_brk_i),
    .btn_load_o(btn_load_o), .btn_look_o(btn_look_o), .btn_step_o(btn_step_o),
    .btn_run_o(btn_run_o), .btn_enter_o(btn_enter_o), .btn_stop_o(btn_stop_o),
    .btn_brk_o(btn_brk_o),
    .led_ready_o(led_ready_o), .led_inwait_o(led_inwait_o), .led_brk_o(led_brk_o),
    .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
    .pc_i(pc_i), .cpu_done_i(cpu_done_i), .cpu_halt_i(cpu_halt_i),
    .inwait_i(inwait_i), .stdin_rdy_i(stdin_rdy_i),
    .core_rst_no(core_rst_no), .cpu_exec_o(cpu_exec_o), .pc_wen_o(pc_wen_o),
    .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdy_i(mem_rdy_i), .mem_rdata_i(mem_rdata_i),
    .disp_o(disp_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory responder: write on accepted write, read data one cycle later.
  always @(posedge clk_i) begin
    if (mem_val_o && mem_rdy_i) begin
      if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o];
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic press_run();
    btn_run_i = 1'b1; tick(); btn_run_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (dbg_state_o !== ST_READY) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state_o, ST_READY); end
    checks++; if ({core_rst_no, cpu_exec_o, led_brk_o} !== 4'b0) begin errors++; $display("FAIL rst_core got %b exp 0000", {core_rst_no, cpu_exec_o, led_brk_o}); end
    checks++; if (disp_o !== '0) begin errors++; $display("FAIL rst_disp got %h exp 0", disp_o); end
    checks++; if ({mem_val_o, mem_wen_o, pc_wen_o, mem_addr_o, mem_wdata_o} !== '0) begin errors++; $display("FAIL rst_mem got val %b addr %h wdata %h exp 0", mem_val_o, mem_addr_o, mem_wdata_o); end
    #2 rst_n = 1'b1;
    tick();
    stdin_rdy_i = 1'($urandom_range(0, 1)); #1;
    checks++; if ({led_ready_o, btn_run_o, btn_step_o, btn_stop_o, led_inwait_o, btn_enter_o} !== {4'b1110, 1'b0, stdin_rdy_i})
      begin errors++; $display("FAIL ready_outs got %b exp %b", {led_ready_o, btn_run_o, btn_step_o, btn_stop_o, led_inwait_o, btn_enter_o}, {4'b1110, 1'b0, stdin_rdy_i}); end
  endtask

  task automatic test_load_look();
    logic [AW-1:0] a, a2;
    logic [DW-1:0] d;
    cpu_done_i = 1'b1; mem_rdy_i = 1'b1;
    for (int it = 0; it < 5; it++) begin
      a = (it == 0) ? 8'h10 : AW'($urandom_range(0, 255));
      d = (it == 0) ? 16'hBEEF : DW'($urandom);
      sw_addr_i = a; sw_data_i = d;
      btn_load_i = 1'b1; btn_look_i = (it == 1);  // both pressed acts as load
      #1;
      checks++; if ({mem_val_o, mem_wen_o, pc_wen_o} !== 3'b111 || mem_addr_o !== a || mem_wdata_o !== d)
        begin errors++; $display("FAIL load_req got val/wen/pcw %b addr %h wdata %h exp 111 %h %h", {mem_val_o, mem_wen_o, pc_wen_o}, mem_addr_o, mem_wdata_o, a, d); end
      tick(); btn_load_i = 1'b0; btn_look_i = 1'b0;
      ref_mem[a] = d; exp_disp = d;
      checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL load_disp got %h exp %h", disp_o, exp_disp); end
      a2 = (it == 0) ? a : AW'($urandom_range(0, 255));
      sw_addr_i = a2; sw_data_i = DW'($urandom); btn_look_i = 1'b1;
      #1;
      checks++; if ({mem_val_o, mem_wen_o, pc_wen_o} !== 3'b101 || mem_addr_o !== a2)
        begin errors++; $display("FAIL look_req got val/wen/pcw %b addr %h exp 101 %h", {mem_val_o, mem_wen_o, pc_wen_o}, mem_addr_o, a2); end
      tick(); btn_look_i = 1'b0;
      checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL look_early got %h exp %h", disp_o, exp_disp); end
      tick();
      exp_disp = ref_mem[a2];
      checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL look_disp got %h exp %h", disp_o, exp_disp); end
    end
    // Unaccepted load is lost: display and memory both unchanged.
    a = AW'($urandom_range(0, 255));
    sw_addr_i = a; sw_data_i = ~ref_mem[a]; mem_rdy_i = 1'b0; btn_load_i = 1'b1;
    tick(); btn_load_i = 1'b0; mem_rdy_i = 1'b1;
    checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL lost_load_disp got %h exp %h", disp_o, exp_disp); end
    btn_look_i = 1'b1; tick(); btn_look_i = 1'b0; tick();
    exp_disp = ref_mem[a];
    checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL lost_load_mem got %h exp %h", disp_o, exp_disp); end
    // No access while the core is busy.
    cpu_done_i = 1'b0; btn_load_i = 1'b1; #1;
    checks++; if ({mem_val_o, pc_wen_o} !== 2'b00) begin errors++; $display("FAIL busy_access got %b exp 00", {mem_val_o, pc_wen_o}); end
    tick(); btn_load_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    logic [DW-1:0] d1, d2;
    cpu_done_i = 1'b1; mem_rdy_i = 1'b1;
    a = AW'($urandom_range(0, 255)); b = a ^ 8'h01;
    d1 = DW'($urandom); d2 = DW'($urandom);
    sw_addr_i = a; sw_data_i = d1; btn_load_i = 1'b1; tick();
    sw_addr_i = b; sw_data_i = d2; tick(); btn_load_i = 1'b0;
    ref_mem[a] = d1; ref_mem[b] = d2;
    checks++; if (disp_o !== d2) begin errors++; $display("FAIL b2b_load got %h exp %h", disp_o, d2); end
    sw_addr_i = a; btn_look_i = 1'b1; tick();
    sw_addr_i = b; tick(); btn_look_i = 1'b0;
    checks++; if (disp_o !== ref_mem[a]) begin errors++; $display("FAIL b2b_look1 got %h exp %h", disp_o, ref_mem[a]); end
    tick();
    checks++; if (disp_o !== ref_mem[b]) begin errors++; $display("FAIL b2b_look2 got %h exp %h", disp_o, ref_mem[b]); end
    cpu_done_i = 1'b0;
    exp_disp = ref_mem[b];
  endtask

  task automatic test_step_burst();
    int n, eff;
    logic [2:0] exp_st;
    cpu_done_i = 1'b0;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 3 : $urandom_range(0, 6);
      eff = (n == 0) ? 1 : n;
      sw_data_i = {12'($urandom), 4'(n)};
      btn_step_i = 1'b1; tick(); btn_step_i = 1'b0;
      checks++; if ({dbg_state_o, cpu_exec_o, core_rst_no} !== {ST_STEP, 2'd2, 1'b1})
        begin errors++; $display("FAIL step_enter got st %0d exec %0d rst %b exp 1 2 1", dbg_state_o, cpu_exec_o, core_rst_no); end
      for (int k = 1; k <= eff; k++) begin
        cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
        exp_st = (k < eff) ? ST_STEP : ST_POST;
        checks++; if (dbg_state_o !== exp_st) begin errors++; $display("FAIL step_count n=%0d k=%0d got %0d exp %0d", n, k, dbg_state_o, exp_st); end
        tick();
      end
      checks++; if ({cpu_exec_o, core_rst_no} !== 3'b001) begin errors++; $display("FAIL post_outs got %b exp 001", {cpu_exec_o, core_rst_no}); end
      cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
      checks++; if (dbg_state_o !== ST_READY) begin errors++; $display("FAIL step_ready got %0d exp %0d", dbg_state_o, ST_READY); end
    end
  endtask

  task automatic test_breakpoint();
    int b;
    bit hit;
    b = $urandom_range(4, 250);
    hit = 1'b0;
    sw_addr_i = AW'(b); btn_brk_i = 1'b1; tick(); btn_brk_i = 1'b0;
    sw_addr_i = AW'(b + 3);
    pc_i = AW'(b - 2); press_run();
    checks++; if ({dbg_state_o, cpu_exec_o, btn_stop_o} !== {ST_RUN, 2'd1, 1'b1})
      begin errors++; $display("FAIL run_enter got st %0d exec %0d stop %b exp 2 1 1", dbg_state_o, cpu_exec_o, btn_stop_o); end
    for (int p = b - 2; p <= b + 1; p++) begin
      if (!hit) begin
        pc_i = AW'(p); tick();
        if (p == b) begin
          hit = 1'b1;
          checks++; if ({dbg_state_o, led_brk_o} !== {ST_POST, 1'b1}) begin errors++; $display("FAIL bp_hit pc=%h got st %0d led %b exp 5 1", p, dbg_state_o, led_brk_o); end
        end else begin
          checks++; if (dbg_state_o !== ST_RUN) begin errors++; $display("FAIL bp_early pc=%h got %0d exp %0d", p, dbg_state_o, ST_RUN); end
        end
      end
    end
    cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
    checks++; if ({dbg_state_o, led_brk_o} !== {ST_READY, 1'b1}) begin errors++; $display("FAIL bp_ready got st %0d led %b exp 0 1", dbg_state_o, led_brk_o); end
    // Clear the breakpoint, then run across its address.
    btn_brk_i = 1'b1; tick(); btn_brk_i = 1'b0;
    pc_i = AW'(b); press_run();
    checks++; if (led_brk_o !== 1'b0) begin errors++; $display("FAIL bp_led_clear got %b exp 0", led_brk_o); end
    tick(); tick();
    checks++; if (dbg_state_o !== ST_RUN) begin errors++; $display("FAIL bp_cleared got %0d exp %0d", dbg_state_o, ST_RUN); end
    btn_stop_i = 1'b1; tick(); btn_stop_i = 1'b0;
    checks++; if ({dbg_state_o, led_brk_o} !== {ST_POST, 1'b0}) begin errors++; $display("FAIL stop got st %0d led %b exp 5 0", dbg_state_o, led_brk_o); end
    cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
  endtask

  task automatic test_inwait();
    logic [AW-1:0] p;
    p = AW'($urandom_range(0, 255));
    pc_i = p; mem_rdy_i = 1'b1;
    press_run();
    inwait_i = 1'b1; tick(); inwait_i = 1'b0;
    checks++; if ({dbg_state_o, core_rst_no, mem_val_o} !== {ST_PRE_WAIT, 2'b10}) begin errors++; $display("FAIL wait_entry got st %0d rst %b val %b exp 3 1 0", dbg_state_o, core_rst_no, mem_val_o); end
    for (int i = 1; i <= ST; i++) begin
      tick();
      checks++; if ({core_rst_no, mem_val_o} !== {1'b0, (i == ST)}) begin errors++; $display("FAIL wait_settle i=%0d got rst %b val %b exp 0 %b", i, core_rst_no, mem_val_o, (i == ST)); end
    end
    checks++; if ({mem_wen_o, mem_addr_o} !== {1'b0, p}) begin errors++; $display("FAIL wait_addr got %h exp %h", mem_addr_o, p); end
    tick();
    checks++; if ({dbg_state_o, led_inwait_o, btn_enter_o, btn_step_o, led_ready_o} !== {ST_INWAIT, 4'b1100})
      begin errors++; $display("FAIL inwait_outs got st %0d %b exp 4 1100", dbg_state_o, {led_inwait_o, btn_enter_o, btn_step_o, led_ready_o}); end
    tick();
    exp_disp = ref_mem[p];
    checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL wait_disp got %h exp %h", disp_o, exp_disp); end
    btn_enter_i = 1'b1; tick(); btn_enter_i = 1'b0;
    checks++; if (dbg_state_o !== ST_READY) begin errors++; $display("FAIL enter_ready got %0d exp %0d", dbg_state_o, ST_READY); end
  endtask

  task automatic test_halt_backpressure();
    logic [AW-1:0] p;
    int d;
    for (int it = 0; it < 2; it++) begin
      d = (it == 0) ? 5 : $urandom_range(2, 7);
      p = AW'($urandom_range(0, 255));
      pc_i = p; press_run();
      cpu_halt_i = 1'b1; tick(); cpu_halt_i = 1'b0; mem_rdy_i = 1'b0;
      checks++; if (dbg_state_o !== ST_PRE_HALT) begin errors++; $display("FAIL halt_entry got %0d exp %0d", dbg_state_o, ST_PRE_HALT); end
      for (int i = 0; i < ST; i++) tick();
      for (int j = 0; j < d; j++) begin
        checks++; if ({dbg_state_o, mem_val_o} !== {ST_PRE_HALT, 1'b1}) begin errors++; $display("FAIL halt_hold j=%0d got st %0d val %b exp 6 1", j, dbg_state_o, mem_val_o); end
        tick();
      end
      mem_rdy_i = 1'b1; tick();
      stdin_rdy_i = 1'($urandom_range(0, 1)); #1;
      checks++; if ({dbg_state_o, mem_val_o, led_ready_o, btn_brk_o, btn_run_o, btn_enter_o} !== {ST_HALT, 4'b0110, stdin_rdy_i})
        begin errors++; $display("FAIL halt_outs got st %0d %b exp 7 0110%b", dbg_state_o, {mem_val_o, led_ready_o, btn_brk_o, btn_run_o, btn_enter_o}, stdin_rdy_i); end
      tick();
      exp_disp = ref_mem[p];
      checks++; if (disp_o !== exp_disp) begin errors++; $display("FAIL halt_disp got %h exp %h", disp_o, exp_disp); end
      btn_look_i = 1'b1; tick(); btn_look_i = 1'b0;
      checks++; if (dbg_state_o !== ST_READY) begin errors++; $display("FAIL halt_exit got %0d exp %0d", dbg_state_o, ST_READY); end
    end
  endtask

  task automatic test_reset_mid();
    pc_i = AW'($urandom_range(0, 255)); press_run();
    cpu_halt_i = 1'b1; tick(); cpu_halt_i = 1'b0; mem_rdy_i = 1'b0;
    for (int i = 0; i < ST; i++) tick();
    checks++; if (mem_val_o !== 1'b1) begin errors++; $display("FAIL mid_pre got val %b exp 1", mem_val_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o} !== '0) begin errors++; $display("FAIL mid_mem got val %b addr %h exp 0", mem_val_o, mem_addr_o); end
    checks++; if ({dbg_state_o, core_rst_no, cpu_exec_o, led_brk_o} !== '0) begin errors++; $display("FAIL mid_state got st %0d rst %b exec %0d exp 0", dbg_state_o, core_rst_no, cpu_exec_o); end
    checks++; if (disp_o !== '0) begin errors++; $display("FAIL mid_disp got %h exp 0", disp_o); end
    tick();
    #2 rst_n = 1'b1; mem_rdy_i = 1'b1;
    tick(); tick();
    checks++; if ({dbg_state_o, mem_val_o, led_ready_o} !== {ST_READY, 2'b01}) begin errors++; $display("FAIL mid_release got st %0d val %b rdy %b exp 0 0 1", dbg_state_o, mem_val_o, led_ready_o); end
  endtask

  initial begin
    checks = 0; errors = 0; exp_disp = '0;
    rst_n = 1'b0;
    {btn_load_i, btn_look_i, btn_step_i, btn_run_i, btn_enter_i, btn_stop_i, btn_brk_i} = '0;
    sw_addr_i = '0; sw_data_i = '0; pc_i = '0;
    cpu_done_i = 1'b0; cpu_halt_i = 1'b0; inwait_i = 1'b0; stdin_rdy_i = 1'b0;
    mem_rdy_i = 1'b1; mem_rdata_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_look();
    test_back_to_back();
    test_step_burst();
    test_breakpoint();
    test_inwait();
    test_halt_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
